tcam_write_sequencer: RTL
=========================

TCAM_WRITE_SEQUENCER -- requirements
Module: tcam_write_sequencer

Interface
REQ-001 Parameter LOOK_UP_DATA_WIDTH, default 144, TCAM key/mask width; fixed at 144, a multiple of REG_DATA_BUS_WIDTH.
REQ-002 Parameter ACTION_WIDTH, default 24, action width.
REQ-003 Parameter REG_ADDR_BUS_WIDTH, default 8, register address width.
REQ-004 Parameter REG_DATA_BUS_WIDTH, default 16, register data width.
REQ-005 Parameter BASE_ADDR, default 8'h40, first TCAM register address.
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 i_req  in  2  per-requester write request, level; bit 0 host, bit 1 learning engine.
REQ-009 i_cmd_type  in  2x3  per-requester command; requester n occupies bits [3n+2:3n].
REQ-010 i_raw_data  in  2x144  per-requester key; slice n is [144n+143:144n].
REQ-011 i_dont_care_mask  in  2x144  per-requester mask, same slicing; 1 = don't care.
REQ-012 i_action_data  in  2x24  per-requester action, same slicing.
REQ-013 o_grant  out  2  one-cycle pulse, one-hot; operands of the granted requester are latched on that edge.
REQ-014 o_done  out  2  one-cycle pulse to the granted requester on completion.
REQ-015 o_timeout  out  1  one-cycle pulse coincident with o_done when the entry was aborted.
REQ-016 o_busy  out  1  high from the grant cycle through the done cycle.
REQ-017 o_reg_bus_we, o_reg_bus_we_addr, o_reg_bus_we_din, o_reg_bus_we_din_v  out  1/8/16/1  register write bus.
REQ-018 i_tcam_busy  in  1  TCAM engine busy.

Function
REQ-019 States: IDLE, WR_DATA, WR_CMD, WAIT_BUSY, DONE.
REQ-020 IDLE: any i_req high and i_tcam_busy low -> o_grant pulse in cycle T, go to WR_DATA; otherwise stay in IDLE.
REQ-021 Arbitration is round-robin: on simultaneous requests, grant the requester not granted last; after reset, requester 0 wins.
REQ-022 WR_DATA issues 20 consecutive single-cycle writes in cycles T+1..T+20, with o_reg_bus_we = o_reg_bus_we_din_v = 1.
REQ-023 Words k = 0..8: addr BASE_ADDR+k, din raw[16k+15:16k].
REQ-024 Words k = 9..17: addr BASE_ADDR+k, din mask[16(k-9)+15:16(k-9)].
REQ-025 Word 18: addr BASE_ADDR+18, din action[15:0].
REQ-026 Word 19: addr BASE_ADDR+19, din {8'h00, action[23:16]}.
REQ-027 WR_CMD at T+21: addr BASE_ADDR+20, din {13'b0, cmd_type}.
REQ-028 Address is computed as BASE_ADDR + word index, modulo 2^REG_ADDR_BUS_WIDTH (wraps, no error).
REQ-029 WAIT_BUSY ignores i_tcam_busy in cycle T+22, then exits on the first cycle with i_tcam_busy low (earliest T+23).
REQ-030 DONE: o_done pulses on the granted bit for 1 cycle, then return to IDLE.
REQ-031 End-to-end minimum latency: grant to done is 23 cycles; the next grant comes no earlier than the cycle after DONE.
REQ-032 Outside WR_DATA/WR_CMD, o_reg_bus_we, o_reg_bus_we_din_v, addr and din are all 0.
REQ-033 Input changes after the grant have no effect on the in-flight entry.
REQ-034 i_req dropped before grant -> no grant.
REQ-035 i_tcam_busy rising during WR_DATA/WR_CMD does not stall writes.

Reset
REQ-036 rst_n low, at any time including mid-entry, forces IDLE and zeroes all outputs immediately.
REQ-037 Reset clears the round-robin pointer to favour requester 0 and the word counter to 0.
REQ-038 An entry interrupted by reset is discarded; no o_done is issued for it.

Configuration
REQ-039 Macro TCAM_WRITE_SEQ_TIMEOUT_EN defined: a 10-bit watchdog counts WAIT_BUSY cycles.
REQ-040 With the macro defined, if WAIT_BUSY lasts 1024 cycles, go to DONE and assert o_done and o_timeout together.
REQ-041 Macro undefined: WAIT_BUSY waits indefinitely and o_timeout is tied to 0.

Verification
REQ-042 Host req, raw=144'h001122334455_00AABBCCDDEE_8100_2123_0800, mask=0, action=24'h123456, busy=0 -> grant T; writes 0x40..0x53 carry 16'h0800 first and 16'h0012 last; cmd at 0x54 din 0; o_done[0] at T+23.
REQ-043 Both req high continuously -> grants alternate 01,10,01,10; no grant while o_busy is high.
REQ-044 i_tcam_busy high from T+22 to T+40 -> o_done at T+41; no bus activity during WAIT_BUSY.
REQ-045 rst_n low at T+10 -> all outputs 0 the same cycle; no o_done; after release, a pending req is granted to requester 0.
REQ-046 With TCAM_WRITE_SEQ_TIMEOUT_EN, busy stuck high -> o_done and o_timeout at T+22+1024; without the macro, no done after 5000 cycles.
REQ-047 BASE_ADDR=8'hF0 -> word 16 goes to addr 8'h00 and cmd to 8'h04.

Source files
------------

// File: rtl/tcam_write_sequencer.sv
// tcam_write_sequencer: arbitrates two TCAM entry writers and serialises the granted entry onto a register write bus.
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   i_req[1:0]          write requests (bit 0 host, bit 1 learning engine)
//   i_cmd_type          per-requester 3-bit command, requester n at [3n+2:3n]
//   i_raw_data          per-requester key, requester n at [LW*n +: LW]
//   i_dont_care_mask    per-requester mask (1 = don't care), same slicing
//   i_action_data       per-requester action, same slicing
//   i_tcam_busy         TCAM engine busy
//   o_grant             one-hot grant pulse; operands latched on that edge
//   o_done              one-cycle completion pulse to the granted requester
//   o_timeout           pulses with o_done when the wait for the engine was abandoned
//   o_busy              high from the grant cycle through the done cycle
//   o_reg_bus_we*       register write bus (strobe, address, data, data valid)
// Build option: define TCAM_WRITE_SEQ_TIMEOUT_EN to abandon the engine wait after 1024 cycles.
module tcam_write_sequencer #(
  parameter int LOOK_UP_DATA_WIDTH = 144,
  parameter int ACTION_WIDTH = 24,
  parameter int REG_ADDR_BUS_WIDTH = 8,
  parameter int REG_DATA_BUS_WIDTH = 16,
  parameter logic [REG_ADDR_BUS_WIDTH-1:0] BASE_ADDR = 8'h40
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [1:0]                      i_req,
  input  logic [5:0]                      i_cmd_type,
  input  logic [2*LOOK_UP_DATA_WIDTH-1:0] i_raw_data,
  input  logic [2*LOOK_UP_DATA_WIDTH-1:0] i_dont_care_mask,
  input  logic [2*ACTION_WIDTH-1:0]       i_action_data,
  output logic [1:0]                      o_grant,
  output logic [1:0]                      o_done,
  output logic                            o_timeout,
  output logic                            o_busy,
  output logic                            o_reg_bus_we,
  output logic [REG_ADDR_BUS_WIDTH-1:0]   o_reg_bus_we_addr,
  output logic [REG_DATA_BUS_WIDTH-1:0]   o_reg_bus_we_din,
  output logic                            o_reg_bus_we_din_v,
  input  logic                            i_tcam_busy
);
  localparam int LW = LOOK_UP_DATA_WIDTH;
  localparam int DW = REG_DATA_BUS_WIDTH;
  localparam int AW = REG_ADDR_BUS_WIDTH;
  localparam int NW = LW / DW;
  localparam int AWD = (ACTION_WIDTH + DW - 1) / DW;
  localparam int NWORDS = 2 * NW + AWD;
  localparam int CW = $clog2(NWORDS + 1);
  typedef enum logic [2:0] {IDLE, WR_DATA, WR_CMD, WAIT_BUSY, DONE} state_t;
  state_t r_state, w_next;
  logic [1:0] w_req, w_grant, r_sel;
  logic r_last;
  logic [CW-1:0] r_cnt, w_idx;
  logic [LW-1:0] r_raw, r_mask;
  logic [ACTION_WIDTH-1:0] r_act;
  logic [2:0] r_cmd;
  logic [NWORDS*DW-1:0] w_flat;
  logic [DW-1:0] w_word;
  logic w_to, w_exit, w_wr;
  // WAIT_BUSY is the single cycle after the command write in which the engine
  // has not yet reacted, so busy is ignored there; DONE then holds until the
  // engine is idle and completes in that same cycle.
  always_comb begin
    w_req = (rst_n && r_state == IDLE && !i_tcam_busy) ? i_req : 2'b00;
    w_grant = &w_req ? (r_last ? 2'b01 : 2'b10) : w_req;
    w_exit = !i_tcam_busy || w_to;
    w_next = r_state == IDLE ? (|w_grant ? WR_DATA : IDLE) :
             r_state == WR_DATA ? (r_cnt == CW'(NWORDS - 1) ? WR_CMD : WR_DATA) :
             r_state == WR_CMD ? WAIT_BUSY :
             r_state == WAIT_BUSY ? DONE :
             (w_exit ? IDLE : DONE);
    w_flat = {(AWD*DW)'(r_act), r_mask, r_raw};
    w_idx = (r_state == WR_DATA) ? r_cnt : '0;
    w_word = w_flat[DW*w_idx +: DW];
    w_wr = r_state == WR_DATA || r_state == WR_CMD;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_sel <= 2'b00;
      r_last <= 1'b1;
      r_raw <= '0;
      r_mask <= '0;
      r_act <= '0;
      r_cmd <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= (r_state == WR_DATA) ? r_cnt + 1'b1 : '0;
      if (|w_grant) begin
        r_sel <= w_grant;
        r_last <= w_grant[1];
        r_raw <= w_grant[1] ? i_raw_data[2*LW-1:LW] : i_raw_data[LW-1:0];
        r_mask <= w_grant[1] ? i_dont_care_mask[2*LW-1:LW] : i_dont_care_mask[LW-1:0];
        r_act <= w_grant[1] ? i_action_data[2*ACTION_WIDTH-1:ACTION_WIDTH] : i_action_data[ACTION_WIDTH-1:0];
        r_cmd <= w_grant[1] ? i_cmd_type[5:3] : i_cmd_type[2:0];
      end
    end
  end
`ifdef TCAM_WRITE_SEQ_TIMEOUT_EN
  logic [9:0] r_wd;
  logic r_to;
  logic w_wait;
  assign w_wait = r_state == WAIT_BUSY || r_state == DONE;
  // r_wd counts cycles since entering WAIT_BUSY; r_to rises once 1024 have elapsed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd <= '0;
      r_to <= 1'b0;
    end else begin
      r_wd <= w_wait ? r_wd + 1'b1 : '0;
      r_to <= w_wait && (r_to || r_wd == 10'h3ff);
    end
  end
  assign w_to = r_to;
`else
  assign w_to = 1'b0;
`endif
  assign o_grant = w_grant;
  assign o_busy = r_state != IDLE || |w_grant;
  assign o_done = (r_state == DONE && w_exit) ? r_sel : 2'b00;
  assign o_timeout = r_state == DONE && w_to;
  assign o_reg_bus_we = w_wr;
  assign o_reg_bus_we_din_v = w_wr;
  assign o_reg_bus_we_addr = w_wr ? BASE_ADDR + AW'(r_cnt) : '0;
  assign o_reg_bus_we_din = r_state == WR_CMD ? DW'(r_cmd) : r_state == WR_DATA ? w_word : '0;
endmodule
